stage_sequencer: RTL

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: instruction-stage sequencer FSM with memory-wait timeout, interrupt detour and halt.
//   clk, rst                          clock and synchronous active-high reset
//   run, interrupt, branch_opcode     control-unit inputs (sampled in IDLE/RB, ID, ALU)
//   mem_read, mem_write, mem_ready    memory handshake (sampled in MEM/MEMW)
//   int_done                          end of interrupt service (sampled in INT)
//   IF_clk..RB_BR_clk                 registered one-hot stage strobes
//   int_ack, halted, bus_err          status; bus_err is sticky until reset
//   state, instr_count                current state code and retired-instruction count
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             interrupt,
    input  logic [2:0]       branch_opcode,
    input  logic [1:0]       mem_read,
    input  logic [1:0]       mem_write,
    input  logic             mem_ready,
    input  logic             int_done,
    output logic             IF_clk,
    output logic             ID_clk,
    output logic             ALU_clk,
    output logic             MEM_clk,
    output logic             RB_BR_clk,
    output logic             int_ack,
    output logic             halted,
    output logic             bus_err,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_IF = 4'd1, S_ID = 4'd2, S_ALU = 4'd3, S_MEM = 4'd4,
        S_MEMW = 4'd5, S_RB = 4'd6, S_INT = 4'd7, S_HALT = 4'd8
    } state_e;

    localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       strobe_q, strobe_d;
    logic             mem_req, timeout;

    assign mem_req = |mem_read || |mem_write;
    assign timeout = wait_q == WW'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
            strobe_q  <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
            strobe_q  <= strobe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_IDLE: state_d = run ? S_IF : S_IDLE;
            S_IF:   state_d = S_ID;
            S_ID:   state_d = interrupt ? S_INT : S_ALU;
            S_ALU:  state_d = branch_opcode == 3'b000 ? S_HALT : S_MEM;
            S_MEM: begin
                state_d = (mem_req && !mem_ready) ? S_MEMW : S_RB;
                wait_d  = '0;
            end
            // mem_ready outranks the timeout when both land in the same cycle
            S_MEMW: begin
                if (mem_ready) begin
                    state_d = S_RB;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_RB:   state_d = run ? S_IF : S_IDLE;
            S_INT:  state_d = int_done ? S_IF : S_INT;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // RB never loops on itself, so landing in RB is always a fresh retirement
    always_comb begin
        cnt_d    = state_d == S_RB ? cnt_q + CNT_W'(1) : cnt_q;
        strobe_d = {state_d == S_RB, state_d == S_MEM, state_d == S_ALU,
                    state_d == S_ID, state_d == S_IF};
    end

    assign IF_clk      = strobe_q[0];
    assign ID_clk      = strobe_q[1];
    assign ALU_clk     = strobe_q[2];
    assign MEM_clk     = strobe_q[3];
    assign RB_BR_clk   = strobe_q[4];
    assign int_ack     = state_q == S_INT;
    assign halted      = state_q == S_HALT;
    assign bus_err     = bus_err_q;
    assign state       = state_q;
    assign instr_count = cnt_q;
endmodule
